// File: rtl/max_track4b.sv
// max_track4b: windowed running-maximum tracker driving an external 4-bit
// magnitude comparator (in_data on x, cmp_y on y) and consuming its
// eq/lt/gt results in the same cycle.
// Optional build macro: MAXTRK_CMP_CHECK_EN enables the sticky comparator
// consistency check on cmp_err; without it cmp_err is tied low.
module max_track4b #(
  parameter int unsigned WINDOW = 8
) (
  input  logic       clk,
  input  logic       rst_b,
  input  logic       start,
  input  logic       in_valid,
  input  logic [3:0] in_data,
  output logic       in_ready,
  output logic [3:0] cmp_y,
  input  logic       cmp_eq,
  input  logic       cmp_lt,
  input  logic       cmp_gt,
  output logic [3:0] max_val,
  output logic [3:0] new_max_cnt,
  output logic [3:0] eq_cnt,
  output logic       done,
  output logic       cmp_err,
  output logic [3:0] state
);

  localparam int unsigned CW = $clog2(WINDOW + 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b1000,
    FIRST = 4'b0100,
    RUN   = 4'b0010,
    DONE  = 4'b0001
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      max_q;
  logic [3:0]      nmax_q;
  logic [3:0]      eq_q;
  logic [CW-1:0]   cnt_q;
  logic            last_acc;
  logic            upd_gt;
  logic            upd_eq;

  // The accept that brings the count to WINDOW is the last of the window.
  assign last_acc = (cnt_q == CW'(WINDOW - 1));

  // A sample flagged "less than" never touches the max or the counters,
  // even if the comparator also raised gt/eq alongside it.
  assign upd_gt = cmp_gt & ~cmp_lt;
  assign upd_eq = cmp_eq & ~cmp_lt;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and state-decoded handshake/done outputs.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = FIRST;
      end
      FIRST: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (WINDOW == 1) ? DONE : RUN;
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && last_acc) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: maximum, event counters and sample count.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      max_q  <= '0;
      nmax_q <= '0;
      eq_q   <= '0;
      cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            max_q  <= '0;
            nmax_q <= '0;
            eq_q   <= '0;
            cnt_q  <= '0;
          end
        end
        FIRST: begin
          if (in_valid) begin
            max_q <= in_data;
            cnt_q <= CW'(1);
          end
        end
        RUN: begin
          if (in_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (upd_gt) begin
              max_q <= in_data;
              if (nmax_q != '1) nmax_q <= nmax_q + 4'd1;
            end
            if (upd_eq && (eq_q != '1)) eq_q <= eq_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MAXTRK_CMP_CHECK_EN
  logic       err_q;
  logic [1:0] hot_sum;
  logic       arith_bad;

  assign hot_sum   = 2'(cmp_eq) + 2'(cmp_lt) + 2'(cmp_gt);
  assign arith_bad = (cmp_gt != (in_data >  max_q)) ||
                     (cmp_lt != (in_data <  max_q)) ||
                     (cmp_eq != (in_data == max_q));

  // Sticky comparator-consistency flag, checked on RUN accepts only.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      err_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      err_q <= 1'b0;
    end else if ((state_q == RUN) && in_valid &&
                 ((hot_sum != 2'd1) || arith_bad)) begin
      err_q <= 1'b1;
    end
  end

  assign cmp_err = err_q;
`else
  assign cmp_err = 1'b0;
`endif

  assign cmp_y       = max_q;
  assign max_val     = max_q;
  assign new_max_cnt = nmax_q;
  assign eq_cnt      = eq_q;
  assign state       = state_q;

endmodule

// File: doc/max_track4b.md
# max_track4b

Windowed running-maximum tracker that consumes the 4-bit magnitude comparator (`cmp4b`) results directly. It accepts a stream of 4-bit samples over a valid/ready handshake and drives the comparator's `y` operand with its current maximum. With the incoming sample on the comparator's `x` operand, it uses `eq`/`lt`/`gt` to update the maximum and its event counters. After `WINDOW` samples it reports results and returns to idle; its one-hot state encoding matches the codebase's FSM blocks.

## Interface
- `WINDOW`, 8: samples per window; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `rst_b`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a new window; honoured only in IDLE.
- `in_valid`  in  1  `in_data` valid.
- `in_data`  in  4  sample; also wired to comparator `x`.
- `in_ready`  out  1  block accepts a sample this cycle.
- `cmp_y`  out  4  current maximum, wired to comparator `y`.
- `cmp_eq`, `cmp_lt`, `cmp_gt`  in  1 each  comparator result for `in_data` vs `cmp_y`, combinational in the same cycle.
- `max_val`  out  4  running and final maximum; equal to `cmp_y`.
- `new_max_cnt`  out  4  number of strict new maxima in RUN; saturates at 15.
- `eq_cnt`  out  4  number of RUN samples equal to the current max; saturates at 15.
- `done`  out  1  one-cycle pulse; results are final.
- `cmp_err`  out  1  sticky comparator-consistency error; see Configuration.
- `state`  out  4  one-hot FSM state.

## Operation
- State encodings: IDLE=4'b1000, FIRST=4'b0100, RUN=4'b0010, DONE=4'b0001.
- A sample is accepted on a cycle where `in_valid & in_ready` is high.
- Sample counter width is clog2(WINDOW+1). It is internal and not exported.
- **IDLE**
  - `in_ready`=0.
  - Results from the previous window are held.
  - On `start`: clear `max_val`, both counters, sample count and `cmp_err`, then go to FIRST.
- **FIRST**
  - `in_ready`=1.
  - On accept: `max_val`<=`in_data` with comparator outputs ignored; count<=1.
  - Next state is RUN, or DONE if WINDOW==1.
- **RUN**
  - `in_ready`=1.
  - On accept: if `cmp_gt`, then `max_val`<=`in_data` and `new_max_cnt`++.
  - On accept: if `cmp_eq`, then `eq_cnt`++.
  - `cmp_lt` leaves the maximum and both counters unchanged.
  - count++ on every accept. When the accept brings count to WINDOW, go to DONE.
- **DONE**
  - `in_ready`=0, `done`=1.
  - Unconditionally go to IDLE next cycle.
- `start` outside IDLE is ignored.
- Cycles with `in_valid`=0 in FIRST or RUN stall with no state change.
- Counters saturate at 15 and never wrap.
- Reset (`rst_b`=0 at a clock edge) overrides every other input in any state. After reset: state=IDLE, `max_val`=`cmp_y`=0, `new_max_cnt`=0, `eq_cnt`=0, `done`=0, `cmp_err`=0, `in_ready`=0.

## Timing
- `in_ready` and `done` are decoded combinationally from `state` only.
- `in_ready` has no combinational path from `in_valid`.
- `cmp_y` is registered. The comparator loop is `cmp_y` -> cmp4b -> `cmp_*` -> register: one combinational pass, no combinational cycle.
- Latency: `done` is high in the cycle immediately after the accept of the WINDOW-th sample.
- Minimum window duration: 1 cycle for `start` + WINDOW accept cycles + 1 DONE cycle. Fastest `start`-to-`done` is WINDOW+1 cycles after the `start` edge.
- `start` may be reasserted in the cycle after DONE, i.e. the first IDLE cycle.

## Configuration
- Macro: `MAXTRK_CMP_CHECK_EN`.
- Defined:
  - On every accepted RUN sample, `cmp_err` is set if `cmp_eq+cmp_lt+cmp_gt` != 1.
  - `cmp_err` is also set if `cmp_gt`/`cmp_lt`/`cmp_eq` disagree with the arithmetic comparison of `in_data` vs `cmp_y`.
  - `cmp_err` is sticky until `start` in IDLE or reset.
  - Datapath behaviour is unchanged.
- Undefined:
  - No check logic is built.
  - `cmp_err` is tied to 0.

## Test plan
- Reset mid-RUN after 2 of 4 accepts, `rst_b`=0 for one edge -> next cycle state=4'b1000, `max_val`=0, counters 0, `in_ready`=0.
- WINDOW=4, samples 3,7,7,2 back-to-back -> `max_val`=7, `new_max_cnt`=1, `eq_cnt`=1, `done` pulses exactly one cycle after the 4th accept.
- WINDOW=4, samples 1,2,3,4 with `in_valid` low for 2 cycles between each -> `max_val`=4, `new_max_cnt`=3, `eq_cnt`=0; no accepts during stalls.
- WINDOW=20, all samples 5 -> `eq_cnt` saturates at 15, `new_max_cnt`=0, `max_val`=5; `start` pulsed during RUN is ignored.
- WINDOW=1, sample 9 -> FIRST goes directly to DONE, `max_val`=9, both counters 0; `start` in the following IDLE cycle clears the results.
- With `MAXTRK_CMP_CHECK_EN`, force `cmp_gt`=`cmp_eq`=1 on one RUN accept -> `cmp_err`=1 and held until the next `start`. Without the macro, the same stimulus leaves `cmp_err`=0.
